// File: rtl/cache_miss_fill_fsm_if.sv
// Bundle of MSHR, victim, memory and fill handshakes for the miss service engine.
// master = miss engine side, slave = surrounding cache/memory side.
interface cache_miss_fill_fsm_if #(
  parameter int unsigned BLOCK_SIZE = 4,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned UUID_W     = 4
);
  logic                         mshr_valid;
  logic [ADDR_W-1:0]            mshr_block_addr;
  logic [BLOCK_SIZE-1:0]        mshr_write_status;
  logic [BLOCK_SIZE*WORD_W-1:0] mshr_write_block;
  logic [UUID_W-1:0]            mshr_uuid;
  logic                         bank_free;

  logic                         victim_req;
  logic                         victim_valid;
  logic                         victim_dirty;
  logic [ADDR_W-1:0]            victim_addr;
  logic [BLOCK_SIZE*WORD_W-1:0] victim_data;

  logic                         mem_req_valid;
  logic                         mem_req_ready;
  logic                         mem_req_rw;
  logic [ADDR_W-1:0]            mem_req_addr;
  logic [WORD_W-1:0]            mem_req_wdata;
  logic                         mem_resp_valid;
  logic [WORD_W-1:0]            mem_resp_rdata;

  logic                         fill_valid;
  logic                         fill_ready;
  logic [ADDR_W-1:0]            fill_addr;
  logic [BLOCK_SIZE*WORD_W-1:0] fill_data;
  logic                         fill_dirty;
  logic [UUID_W-1:0]            fill_uuid;

  modport master (
    input  mshr_valid, mshr_block_addr, mshr_write_status, mshr_write_block, mshr_uuid,
    output bank_free,
    output victim_req,
    input  victim_valid, victim_dirty, victim_addr, victim_data,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output fill_valid, fill_addr, fill_data, fill_dirty, fill_uuid,
    input  fill_ready
  );

  modport slave (
    output mshr_valid, mshr_block_addr, mshr_write_status, mshr_write_block, mshr_uuid,
    input  bank_free,
    input  victim_req,
    output victim_valid, victim_dirty, victim_addr, victim_data,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  fill_valid, fill_addr, fill_data, fill_dirty, fill_uuid,
    output fill_ready
  );
endinterface

// File: rtl/cache_miss_fill_fsm.sv
// Per-bank miss service engine: pop MSHR head, write back dirty victim, fetch and merge line, install.
// Optional performance counters enabled with `define CACHE_MISS_FILL_PERF_EN.
module cache_miss_fill_fsm #(
  parameter int unsigned BLOCK_SIZE = 4,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned UUID_W     = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  cache_miss_fill_fsm_if.master bus
`ifdef CACHE_MISS_FILL_PERF_EN
  ,
  output logic [31:0]           perf_fills,
  output logic [31:0]           perf_writebacks,
  output logic [31:0]           perf_busy_cycles
`endif
);
  localparam int unsigned WORD_B = WORD_W / 8;
  localparam int unsigned IDX_W  = $clog2(BLOCK_SIZE);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BLOCK_SIZE * WORD_B - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_VICTIM  = 3'd1;
  localparam logic [2:0] S_WB      = 3'd2;
  localparam logic [2:0] S_FILL    = 3'd3;
  localparam logic [2:0] S_INSTALL = 3'd4;

  logic [2:0]                         state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic                               waiting_q, waiting_d;
  logic [ADDR_W-1:0]                  blk_addr_q, blk_addr_d;
  logic [BLOCK_SIZE-1:0]              status_q, status_d;
  logic [BLOCK_SIZE-1:0][WORD_W-1:0]  line_q, line_d;
  logic [UUID_W-1:0]                  uuid_q, uuid_d;
  logic                               dirty_q, dirty_d;
  logic [ADDR_W-1:0]                  vic_addr_q, vic_addr_d;
  logic [BLOCK_SIZE-1:0][WORD_W-1:0]  vic_data_q, vic_data_d;

  logic                               bank_free_q, bank_free_d;
  logic                               victim_req_q, victim_req_d;
  logic                               mem_valid_q, mem_valid_d;
  logic                               mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]                  mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]                  mem_wdata_q, mem_wdata_d;
  logic                               fill_valid_q, fill_valid_d;

  logic                               mem_hs;
  logic                               fill_hs;

  assign mem_hs  = mem_valid_q && bus.mem_req_ready;
  assign fill_hs = fill_valid_q && bus.fill_ready;
  assign idx_q   = cnt_q[IDX_W-1:0];

  // Next state, captured data and next registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    waiting_d  = waiting_q;
    blk_addr_d = blk_addr_q;
    status_d   = status_q;
    line_d     = line_q;
    uuid_d     = uuid_q;
    dirty_d    = dirty_q;
    vic_addr_d = vic_addr_q;
    vic_data_d = vic_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.mshr_valid) begin
          blk_addr_d = bus.mshr_block_addr & ALIGN_MASK;
          status_d   = bus.mshr_write_status;
          line_d     = bus.mshr_write_block;
          uuid_d     = bus.mshr_uuid;
          dirty_d    = |bus.mshr_write_status;
          cnt_d      = '0;
          waiting_d  = 1'b0;
          // A fully written line needs neither the victim nor memory.
          state_d    = (&bus.mshr_write_status) ? S_INSTALL : S_VICTIM;
        end
      end
      S_VICTIM: begin
        if (bus.victim_valid) begin
          vic_addr_d = bus.victim_addr;
          vic_data_d = bus.victim_data;
          cnt_d      = '0;
          state_d    = bus.victim_dirty ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        if (mem_hs) begin
          if (cnt_q == CNT_W'(BLOCK_SIZE - 1)) begin
            cnt_d   = '0;
            state_d = S_FILL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FILL: begin
        if (!waiting_q) begin
          if (mem_hs) waiting_d = 1'b1;
        end else if (bus.mem_resp_valid) begin
          waiting_d = 1'b0;
          // Pending store data wins over the fetched word.
          if (!status_q[idx_q]) line_d[idx_q] = bus.mem_resp_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(BLOCK_SIZE)) begin
            cnt_d   = '0;
            state_d = S_INSTALL;
          end
        end
      end
      S_INSTALL: begin
        if (fill_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    idx_d        = cnt_d[IDX_W-1:0];
    bank_free_d  = (state_d == S_IDLE);
    victim_req_d = (state_d == S_VICTIM);
    mem_valid_d  = (state_d == S_WB) || ((state_d == S_FILL) && !waiting_d);
    mem_rw_d     = (state_d == S_WB);
    fill_valid_d = (state_d == S_INSTALL);
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    if (state_d == S_WB) begin
      mem_addr_d  = vic_addr_d + ADDR_W'(cnt_d) * ADDR_W'(WORD_B);
      mem_wdata_d = vic_data_d[idx_d];
    end else if (state_d == S_FILL) begin
      mem_addr_d  = blk_addr_d + ADDR_W'(cnt_d) * ADDR_W'(WORD_B);
    end
  end

  // State, captured data and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      waiting_q    <= 1'b0;
      blk_addr_q   <= '0;
      status_q     <= '0;
      line_q       <= '0;
      uuid_q       <= '0;
      dirty_q      <= 1'b0;
      vic_addr_q   <= '0;
      vic_data_q   <= '0;
      bank_free_q  <= 1'b1;
      victim_req_q <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      fill_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      waiting_q    <= waiting_d;
      blk_addr_q   <= blk_addr_d;
      status_q     <= status_d;
      line_q       <= line_d;
      uuid_q       <= uuid_d;
      dirty_q      <= dirty_d;
      vic_addr_q   <= vic_addr_d;
      vic_data_q   <= vic_data_d;
      bank_free_q  <= bank_free_d;
      victim_req_q <= victim_req_d;
      mem_valid_q  <= mem_valid_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fill_valid_q <= fill_valid_d;
    end
  end

  assign bus.bank_free     = bank_free_q;
  assign bus.victim_req    = victim_req_q;
  assign bus.mem_req_valid = mem_valid_q;
  assign bus.mem_req_rw    = mem_rw_q;
  assign bus.mem_req_addr  = mem_addr_q;
  assign bus.mem_req_wdata = mem_wdata_q;
  assign bus.fill_valid    = fill_valid_q;
  assign bus.fill_addr     = blk_addr_q;
  assign bus.fill_data     = line_q;
  assign bus.fill_dirty    = dirty_q;
  assign bus.fill_uuid     = uuid_q;

`ifdef CACHE_MISS_FILL_PERF_EN
  // Saturating event counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_fills       <= '0;
      perf_writebacks  <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (fill_hs && (perf_fills != '1)) perf_fills <= perf_fills + 32'd1;
      if ((state_q == S_WB) && mem_hs && (cnt_q == CNT_W'(BLOCK_SIZE - 1)) &&
          (perf_writebacks != '1))
        perf_writebacks <= perf_writebacks + 32'd1;
      if ((state_q != S_IDLE) && (perf_busy_cycles != '1))
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_miss_fill_fsm.sv
// Self-checking bench for cache_miss_fill_fsm: directed plan plus randomized misses against a list-level model.
module tb_cache_miss_fill_fsm;
  localparam int unsigned BS = 4;
  localparam int unsigned WW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned UW = 4;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic CLK;
  logic RST;
  cache_miss_fill_fsm_if #(.BLOCK_SIZE(BS), .WORD_W(WW), .ADDR_W(AW), .UUID_W(UW)) bus ();

`ifdef CACHE_MISS_FILL_PERF_EN
  logic [31:0] perf_fills, perf_writebacks, perf_busy_cycles;
`endif

  cache_miss_fill_fsm #(.BLOCK_SIZE(BS), .WORD_W(WW), .ADDR_W(AW), .UUID_W(UW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef CACHE_MISS_FILL_PERF_EN
    ,
    .perf_fills       (perf_fills),
    .perf_writebacks  (perf_writebacks),
    .perf_busy_cycles (perf_busy_cycles)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Environment knobs and shared observations.
  logic [31:0]  rd_words [4];
  logic         cur_vdirty;
  logic [31:0]  cur_vaddr;
  logic [127:0] cur_vdata;
  bit           rand_ready  = 1'b0;
  bit           rand_victim = 1'b0;
  int           resp_lat    = 1;
  int           mem_hold    = 0;
  int           fill_hold   = 0;
  bit           stray       = 1'b0;
  req_t         log_q [$];
  int           pops = 0, victim_req_cycles = 0, victim_hs = 0, resp_count = 0, fill_hs = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Victim/memory/fill responders and handshake monitor.
  initial begin
    bit           resp_pend  = 1'b0;
    int           resp_wait  = 0;
    logic [31:0]  resp_addr  = '0;
    bit           mem_stall  = 1'b0;
    bit           fill_stall = 1'b0;
    req_t         cur, prev;
    logic [164:0] fill_prev, fill_cur;
    prev      = '0;
    fill_prev = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        resp_pend  = 1'b0;
        mem_stall  = 1'b0;
        fill_stall = 1'b0;
      end else begin
        if (bus.mshr_valid && bus.bank_free) pops++;
        if (bus.victim_req) victim_req_cycles++;
        if (bus.victim_req && bus.victim_valid) victim_hs++;
        cur.rw    = bus.mem_req_rw;
        cur.addr  = bus.mem_req_addr;
        cur.wdata = bus.mem_req_rw ? bus.mem_req_wdata : 32'h0;
        if (mem_stall) check("mem_req_stable", 128'({bus.mem_req_valid, cur}), 128'({1'b1, prev}));
        mem_stall = 1'b0;
        if (bus.mem_req_valid) begin
          if (bus.mem_req_ready) begin
            log_q.push_back(cur);
            if (!bus.mem_req_rw) begin
              if (resp_pend) check("one_outstanding", 128'(1), 128'(0));
              resp_pend = 1'b1;
              resp_wait = resp_lat;
              resp_addr = bus.mem_req_addr;
            end
          end else begin
            mem_stall = 1'b1;
            prev      = cur;
          end
        end
        fill_cur = {bus.fill_valid, bus.fill_addr, bus.fill_data, bus.fill_dirty, bus.fill_uuid};
        if (fill_stall) check("fill_stable", 128'(fill_cur ^ fill_prev), 128'(0));
        fill_stall = bus.fill_valid && !bus.fill_ready;
        fill_prev  = fill_cur;
        if (bus.fill_valid && bus.fill_ready) fill_hs++;
      end
      @(posedge CLK);
      #1;
      if (bus.mem_req_valid && mem_hold > 0) begin
        bus.mem_req_ready = 1'b0;
        mem_hold--;
      end else begin
        bus.mem_req_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = $urandom();
      if (stray) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'hDEAD_BEEF;
        stray = 1'b0;
      end else if (resp_pend) begin
        resp_wait--;
        if (resp_wait <= 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_rdata = rd_words[resp_addr[3:2]];
          resp_pend = 1'b0;
          resp_count++;
        end
      end
      bus.victim_valid = bus.victim_req && (!rand_victim || ($urandom_range(0, 1) == 1));
      bus.victim_dirty = cur_vdirty;
      bus.victim_addr  = cur_vaddr;
      bus.victim_data  = cur_vdata;
      if (bus.fill_valid && fill_hold > 0) begin
        bus.fill_ready = 1'b0;
        fill_hold--;
      end else begin
        bus.fill_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
    end
  end

  // One complete miss: model builds the expected request list and merged line.
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] st, input logic [127:0] blk,
                         input logic [3:0] uuid, input bit keep_valid, input string tag);
    req_t         exp_q [$];
    req_t         e;
    logic [127:0] exp_line;
    logic [31:0]  base;
    bit           bypass, got, done, seen;
    int           lat;
    base   = addr & 32'hFFFF_FFF0;
    bypass = (st == 4'hF);
    if (!bypass) begin
      if (cur_vdirty)
        for (int i = 0; i < 4; i++) begin
          e.rw = 1'b1; e.addr = cur_vaddr + 32'(4 * i); e.wdata = cur_vdata[i*32 +: 32];
          exp_q.push_back(e);
        end
      for (int i = 0; i < 4; i++) begin
        e.rw = 1'b0; e.addr = base + 32'(4 * i); e.wdata = 32'h0;
        exp_q.push_back(e);
      end
    end
    for (int i = 0; i < 4; i++)
      exp_line[i*32 +: 32] = st[i] ? blk[i*32 +: 32] : rd_words[i];

    log_q.delete();
    pops = 0; victim_req_cycles = 0; victim_hs = 0;
    @(posedge CLK); #1;
    bus.mshr_valid = 1'b1; bus.mshr_block_addr = addr; bus.mshr_write_status = st;
    bus.mshr_write_block = blk; bus.mshr_uuid = uuid;
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      if (bus.bank_free) begin got = 1'b1; break; end
    end
    check({tag, "_accept"}, 128'(got), 128'(1));
    @(posedge CLK); #1;
    if (keep_valid) begin
      bus.mshr_block_addr = 32'hCAFE_0000; bus.mshr_write_status = 4'h0; bus.mshr_uuid = ~uuid;
    end else begin
      bus.mshr_valid = 1'b0;
    end
    done = 1'b0; seen = 1'b0; lat = 0;
    for (int c = 1; c < 2000; c++) begin
      @(negedge CLK);
      if (bus.fill_valid && !seen) begin seen = 1'b1; lat = c; end
      if (bus.fill_valid && bus.fill_ready) begin done = 1'b1; break; end
    end
    check({tag, "_fill_done"}, 128'(done), 128'(1));
    check({tag, "_fill_data"}, bus.fill_data, exp_line);
    check({tag, "_fill_addr"}, 128'(bus.fill_addr), 128'(base));
    check({tag, "_fill_dirty"}, 128'(bus.fill_dirty), 128'(|st));
    check({tag, "_fill_uuid"}, 128'(bus.fill_uuid), 128'(uuid));
    if (bypass) begin
      check({tag, "_bypass_lat"}, 128'(lat), 128'(1));
      check({tag, "_no_victim_req"}, 128'(victim_req_cycles), 128'(0));
    end else begin
      check({tag, "_victim_hs"}, 128'(victim_hs), 128'(1));
    end
    check({tag, "_nreq"}, 128'(log_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_req%0d", tag, i), 128'(log_q[i]), 128'(exp_q[i]));
    @(posedge CLK); #1;
    bus.mshr_valid = 1'b0;
    check({tag, "_pops"}, 128'(pops), 128'(1));
    check({tag, "_free_after"}, 128'({bus.bank_free, bus.fill_valid}), 128'(2'b10));
  endtask

  initial begin
    logic [127:0] blk;
    logic [3:0]   st;
    bit           got;
    int           base_cnt, fills_before, bad_free, bad_fill, fill_hs_base;
    RST = 1'b1;
    bus.mshr_valid = 1'b0; bus.mshr_block_addr = '0; bus.mshr_write_status = '0;
    bus.mshr_write_block = '0; bus.mshr_uuid = '0;
    bus.victim_valid = 1'b0; bus.victim_dirty = 1'b0; bus.victim_addr = '0; bus.victim_data = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0;
    bus.fill_ready = 1'b0;
    cur_vdirty = 1'b0; cur_vaddr = 32'h300; cur_vdata = '0;
    for (int i = 0; i < 4; i++) rd_words[i] = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_free", 128'(bus.bank_free), 128'(1));
    check("reset_outs", 128'({bus.victim_req, bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr,
                              bus.mem_req_wdata, bus.fill_valid, bus.fill_addr, bus.fill_dirty,
                              bus.fill_uuid}), 128'(0));
    check("reset_fill_data", bus.fill_data, 128'(0));
    @(posedge CLK); #1;
    RST = 1'b0;

    for (int i = 0; i < 4; i++) rd_words[i] = 32'hA0 + 32'(i);
    run_txn(32'h100, 4'b0000, {4{32'h5555_5555}}, 4'h3, 1'b0, "clean");

    for (int i = 0; i < 4; i++) rd_words[i] = 32'hB0 + 32'(i);
    run_txn(32'h240, 4'b0101, {32'h99, 32'h33, 32'h99, 32'h11}, 4'h9, 1'b0, "partial");

    cur_vdirty = 1'b1; cur_vaddr = 32'h200;
    cur_vdata = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    for (int i = 0; i < 4; i++) rd_words[i] = 32'hC0 + 32'(i);
    run_txn(32'h400, 4'b0000, '0, 4'h5, 1'b0, "dirty");

    run_txn(32'h50C, 4'b1111, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 4'hA, 1'b0, "bypass");

    mem_hold = 5; fill_hold = 3;
    run_txn(32'h600, 4'b0010, {32'h0, 32'h0, 32'h77, 32'h0}, 4'hC, 1'b1, "backpressure");

    // Reset in the middle of the read phase, then a stray response.
    cur_vdirty = 1'b0;
    base_cnt = resp_count;
    fills_before = fill_hs;
    @(posedge CLK); #1;
    bus.mshr_valid = 1'b1; bus.mshr_block_addr = 32'h700; bus.mshr_write_status = 4'h0; bus.mshr_uuid = 4'h7;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (resp_count >= base_cnt + 2) begin got = 1'b1; break; end
      if (bus.bank_free && c > 0) bus.mshr_valid = 1'b0;
    end
    check("rst_two_words", 128'(got), 128'(1));
    @(posedge CLK); #1;
    bus.mshr_valid = 1'b0;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_mid_free", 128'({bus.bank_free, bus.mem_req_valid, bus.fill_valid}), 128'(3'b100));
    @(posedge CLK); #1;
    RST = 1'b0;
    fill_hs_base = fill_hs;
    stray = 1'b1;
    bad_free = 0; bad_fill = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (!bus.bank_free || bus.mem_req_valid) bad_free++;
      if (bus.fill_valid) bad_fill++;
    end
    check("rst_stays_idle", 128'(bad_free), 128'(0));
    check("rst_no_fill", 128'(bad_fill + fill_hs - fills_before), 128'(0));

    // Randomized misses with random handshake timing.
    rand_ready = 1'b1; rand_victim = 1'b1;
    for (int t = 0; t < 24; t++) begin
      resp_lat   = int'($urandom_range(1, 3));
      cur_vdirty = ($urandom_range(0, 1) == 1);
      cur_vaddr  = (t == 3) ? 32'hFFFF_FFF8 : $urandom();
      cur_vdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int i = 0; i < 4; i++) rd_words[i] = $urandom();
      blk = {$urandom(), $urandom(), $urandom(), $urandom()};
      case (t % 6)
        0:       st = 4'h0;
        1:       st = 4'hF;
        default: st = 4'($urandom_range(0, 15));
      endcase
      run_txn($urandom(), st, blk, 4'($urandom_range(0, 15)), (t % 5) == 0, $sformatf("rand%0d", t));
    end

`ifdef CACHE_MISS_FILL_PERF_EN
    check("perf_fills", 128'(perf_fills), 128'(fill_hs - fill_hs_base));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
